tm_axis_packetizer: RTL and testbench
=====================================

TM_AXIS_PACKETIZER -- requirements
Module: tm_axis_packetizer

Interface
REQ-001 SHALL have parameter PACKETS_NUM, default 13: beats (packets) per datapoint, 2..64.
REQ-002 SHALL have parameter C_S00_AXIS_TDATA_WIDTH, default 64: stream data width.
REQ-003 SHALL have parameter DP_CNT_W, default 32: datapoint counter width.
REQ-004 SHALL provide clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL provide rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL provide s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  incoming feature packet.
REQ-007 SHALL provide s00_axis_tvalid  in  1  upstream beat valid.
REQ-008 SHALL provide s00_axis_tlast  in  1  final beat of the DMA transfer.
REQ-009 SHALL provide s00_axis_tready  out  1  beat acceptance.
REQ-010 SHALL provide x  out  C_S00_AXIS_TDATA_WIDTH  registered copy of last accepted tdata.
REQ-011 SHALL provide valid  out  PACKETS_NUM  one-hot packet strobe to the clause blocks.
REQ-012 SHALL provide packet_counter  out  $clog2(PACKETS_NUM)  index of packet currently on x.
REQ-013 SHALL provide last  out  1  transfer-end pulse to the inference core.
REQ-014 SHALL provide finish  in  1  one-cycle result-consumed pulse from the inference core.
REQ-015 SHALL provide frame_err  out  1  sticky framing error.
REQ-016 SHALL provide dp_count  out  DP_CNT_W  completed datapoints, wraps modulo 2^DP_CNT_W.

Function
REQ-017 SHALL implement two states: RECV (tready=1) and WAIT (tready=0); tready decoded from the state register only, never from tvalid.
REQ-018 SHALL accept a beat when tvalid && tready; an internal index idx (0..PACKETS_NUM-1) selects the packet slot.
REQ-019 SHALL, one cycle after acceptance, present x=tdata, packet_counter=idx, valid=1<<idx for exactly one cycle; valid SHALL be all-zero in every other cycle.
REQ-020 SHALL hold x and packet_counter stable between acceptances.
REQ-021 SHALL increment idx on each acceptance; on acceptance at idx=PACKETS_NUM-1, wrap idx to 0, transition RECV->WAIT, increment dp_count.
REQ-022 SHALL leave WAIT for RECV on the cycle after finish=1; finish while in RECV SHALL be ignored.
REQ-023 SHALL latch a pending-last flag on any accepted beat with tlast=1.
REQ-024 SHALL pulse last for one cycle coincident with valid[PACKETS_NUM-1] of the datapoint that carried tlast, then clear the pending flag.
REQ-025 SHALL, on tlast accepted at idx != PACKETS_NUM-1, set frame_err, still emit that beat's valid strobe, pulse last with it, reset idx to 0, remain in RECV, and not increment dp_count.
REQ-026 SHALL keep frame_err set until rst.
REQ-027 SHALL never accept a beat in WAIT; at most one datapoint in flight.
REQ-028 SHALL tolerate tvalid gaps of any length between beats without losing idx.

Reset
REQ-029 SHALL, while rst=1, force state=RECV, idx=0, x=0, valid=0, packet_counter=0, last=0, pending-last=0, frame_err=0, dp_count=0; s00_axis_tready=1 from the first clock edge after rst deasserts.
REQ-030 SHALL discard any partial datapoint when rst asserts mid-operation; no valid/last pulses follow until new beats arrive.

Verification
REQ-031 SHALL pass: 13 back-to-back beats tdata=0..12, no tlast -> valid walks 0x0001..0x1000 one per cycle, x matches, tready=0 after beat 12, dp_count=1.
REQ-032 SHALL pass: in WAIT, tvalid=1 held 20 cycles then finish pulse -> no acceptance until cycle after finish, then beat 0 accepted, valid=0x0001.
REQ-033 SHALL pass: 13 beats with tlast on beat 12 -> last=1 in the same cycle as valid=0x1000, single pulse, frame_err=0.
REQ-034 SHALL pass: tlast on beat 5 -> frame_err=1, last with valid=0x0020, next beat yields valid=0x0001, dp_count unchanged.
REQ-035 SHALL pass: rst asserted after beat 7 -> all outputs zero, tready=1; next 13 beats produce a full normal datapoint.
REQ-036 SHALL pass: beats separated by random 0-5 cycle tvalid gaps -> identical valid/x sequence as REQ-031.

Source files
------------

// File: rtl/tm_axis_packetizer.sv
// Packetizes an AXI-Stream feature transfer into PACKETS_NUM one-hot packet strobes per datapoint,
// stalling the stream until the inference core signals that it has consumed the result.
module tm_axis_packetizer #(
  parameter int unsigned PACKETS_NUM            = 13,
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int unsigned DP_CNT_W               = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic                                  s00_axis_tvalid,
  input  logic                                  s00_axis_tlast,
  output logic                                  s00_axis_tready,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0]     x,
  output logic [PACKETS_NUM-1:0]                valid,
  output logic [$clog2(PACKETS_NUM)-1:0]        packet_counter,
  output logic                                  last,
  input  logic                                  finish,
  output logic                                  frame_err,
  output logic [DP_CNT_W-1:0]                   dp_count
);

  localparam int unsigned IDX_W = $clog2(PACKETS_NUM);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACKETS_NUM - 1);

  typedef enum logic {
    ST_RECV = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   x_q, x_d;
  logic [PACKETS_NUM-1:0]              valid_q, valid_d;
  logic [IDX_W-1:0]                    pc_q, pc_d;
  logic                                last_q, last_d;
  logic                                pending_q, pending_d;
  logic                                frame_err_q, frame_err_d;
  logic [DP_CNT_W-1:0]                 dp_count_q, dp_count_d;
  logic                                at_end_c;

  assign at_end_c = (idx_q == IDX_LAST);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RECV;
      idx_q       <= '0;
      x_q         <= '0;
      valid_q     <= '0;
      pc_q        <= '0;
      last_q      <= 1'b0;
      pending_q   <= 1'b0;
      frame_err_q <= 1'b0;
      dp_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      last_q      <= last_d;
      pending_q   <= pending_d;
      frame_err_q <= frame_err_d;
      dp_count_q  <= dp_count_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = x_q;
    valid_d     = '0;
    pc_d        = pc_q;
    last_d      = 1'b0;
    pending_d   = pending_q;
    frame_err_d = frame_err_q;
    dp_count_d  = dp_count_q;

    case (state_q)
      ST_RECV: begin
        if (s00_axis_tvalid) begin
          x_d     = s00_axis_tdata;
          pc_d    = idx_q;
          valid_d = PACKETS_NUM'(1) << idx_q;
          if (s00_axis_tlast) begin
            pending_d = 1'b1;
          end
          // last rides with the final strobe of the datapoint, or with a premature tlast beat
          if (s00_axis_tlast || (pending_q && at_end_c)) begin
            last_d    = 1'b1;
            pending_d = 1'b0;
          end
          if (s00_axis_tlast && !at_end_c) begin
            frame_err_d = 1'b1;
            idx_d       = '0;
          end else if (at_end_c) begin
            idx_d      = '0;
            state_d    = ST_WAIT;
            dp_count_d = dp_count_q + DP_CNT_W'(1);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (finish) begin
          state_d = ST_RECV;
        end
      end
      default: state_d = ST_RECV;
    endcase
  end

  assign s00_axis_tready = (state_q == ST_RECV);
  assign x               = x_q;
  assign valid           = valid_q;
  assign packet_counter  = pc_q;
  assign last            = last_q;
  assign frame_err       = frame_err_q;
  assign dp_count        = dp_count_q;

endmodule

// File: tb/tb_tm_axis_packetizer.sv
// Randomized self-checking bench for tm_axis_packetizer against a datapoint-level reference model.
module tb_tm_axis_packetizer;

  localparam int unsigned N  = 13;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 32;
  localparam int unsigned PW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] tdata = '0;
  logic          tvalid = 1'b0;
  logic          tlast = 1'b0;
  logic          finish = 1'b0;
  logic          tready;
  logic [DW-1:0] x;
  logic [N-1:0]  valid;
  logic [PW-1:0] packet_counter;
  logic          last;
  logic          frame_err;
  logic [CW-1:0] dp_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: slot index, datapoints done, pending tlast, sticky error
  int m_idx = 0;
  int m_dp = 0;
  bit m_pending = 1'b0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  tm_axis_packetizer #(
    .PACKETS_NUM(N),
    .C_S00_AXIS_TDATA_WIDTH(DW),
    .DP_CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s00_axis_tdata(tdata),
    .s00_axis_tvalid(tvalid),
    .s00_axis_tlast(tlast),
    .s00_axis_tready(tready),
    .x(x),
    .valid(valid),
    .packet_counter(packet_counter),
    .last(last),
    .finish(finish),
    .frame_err(frame_err),
    .dp_count(dp_count)
  );

  task automatic model_reset();
    m_idx = 0;
    m_dp = 0;
    m_pending = 1'b0;
    m_err = 1'b0;
  endtask

  // Expected strobe for one accepted beat, then advance the model
  task automatic model_accept(input logic tl, output logic [N-1:0] ev,
                              output logic [PW-1:0] epc, output logic el);
    ev = '0;
    ev[m_idx] = 1'b1;
    epc = PW'(m_idx);
    if (tl) m_pending = 1'b1;
    el = m_pending && (tl || m_idx == N - 1);
    if (el) m_pending = 1'b0;
    if (tl && m_idx != N - 1) begin
      m_err = 1'b1;
      m_idx = 0;
    end else if (m_idx == N - 1) begin
      m_idx = 0;
      m_dp = m_dp + 1;
    end else begin
      m_idx = m_idx + 1;
    end
  endtask

  // Offer one beat after an idle gap; return what the DUT showed the cycle after acceptance
  task automatic send_beat(input logic [DW-1:0] d, input logic tl, input int gap,
                           output bit acc, output int stray, output logic [N-1:0] ov,
                           output logic [DW-1:0] ox, output logic [PW-1:0] opc, output logic ol);
    bit can;
    stray = 0;
    acc = 1'b0;
    tvalid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      if (valid !== '0 || last !== 1'b0) stray++;
    end
    tdata = d;
    tlast = tl;
    tvalid = 1'b1;
    for (int c = 0; c < 100 && !acc; c++) begin
      can = tready;
      @(posedge clk); #1;
      if (can) acc = 1'b1;
      else if (valid !== '0 || last !== 1'b0) stray++;
    end
    tvalid = 1'b0;
    tlast = 1'b0;
    ov = valid;
    ox = x;
    opc = packet_counter;
    ol = last;
  endtask

  task automatic pulse_finish(input int delay);
    tvalid = 1'b0;
    for (int i = 0; i < delay; i++) begin
      @(posedge clk); #1;
    end
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vectors++; if (valid !== '0 || last !== 1'b0 || x !== '0 || packet_counter !== '0) begin
      miscompares++; $display("FAIL reset_outputs valid=%h last=%b x=%h pc=%0d want all zero", valid, last, x, packet_counter); end
    vectors++; if (frame_err !== 1'b0 || dp_count !== '0) begin
      miscompares++; $display("FAIL reset_status frame_err=%b dp_count=%0d want 0/0", frame_err, dp_count); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    vectors++; if (tready !== 1'b1) begin
      miscompares++; $display("FAIL reset_tready got=%b want=1", tready); end
  endtask

  task automatic test_back_to_back();
    bit acc; int stray; logic [N-1:0] ov, ev; logic [DW-1:0] ox; logic [PW-1:0] opc, epc; logic ol, el;
    for (int i = 0; i < N; i++) begin
      send_beat(DW'(i), 1'b0, 0, acc, stray, ov, ox, opc, ol);
      model_accept(1'b0, ev, epc, el);
      vectors++; if (!acc || stray != 0 || ov !== ev || ox !== DW'(i) || opc !== epc || ol !== el) begin
        miscompares++; $display("FAIL b2b_beat%0d acc=%b stray=%0d valid=%h x=%0d pc=%0d last=%b want valid=%h x=%0d pc=%0d last=%b",
                                i, acc, stray, ov, ox, opc, ol, ev, i, epc, el); end
    end
    vectors++; if (tready !== 1'b0 || dp_count !== CW'(m_dp)) begin
      miscompares++; $display("FAIL b2b_end tready=%b dp_count=%0d want 0/%0d", tready, dp_count, m_dp); end
  endtask

  task automatic test_wait_finish();
    bit acc; int stray; logic [N-1:0] ov, ev; logic [DW-1:0] ox; logic [PW-1:0] opc, epc; logic ol, el;
    int bad = 0;
    tdata = DW'(64'hA5A5_0000_1234_5678);
    tvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (tready !== 1'b0 || valid !== '0) bad++;
    end
    vectors++; if (bad != 0) begin
      miscompares++; $display("FAIL wait_hold bad_cycles=%0d want 0", bad); end
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    vectors++; if (valid !== '0 || tready !== 1'b1) begin
      miscompares++; $display("FAIL wait_finish_cycle valid=%h tready=%b want 0/1", valid, tready); end
    @(posedge clk); #1;
    tvalid = 1'b0;
    model_accept(1'b0, ev, epc, el);
    vectors++; if (valid !== ev || x !== DW'(64'hA5A5_0000_1234_5678) || ev !== N'(1)) begin
      miscompares++; $display("FAIL wait_first_beat valid=%h x=%h want valid=%h", valid, x, ev); end
    for (int i = 1; i < N; i++) begin
      send_beat(DW'($urandom), (i == N - 1), 0, acc, stray, ov, ox, opc, ol);
      model_accept((i == N - 1), ev, epc, el);
      vectors++; if (!acc || stray != 0 || ov !== ev || opc !== epc || ol !== el) begin
        miscompares++; $display("FAIL tlast_beat%0d acc=%b stray=%0d valid=%h pc=%0d last=%b want valid=%h pc=%0d last=%b",
                                i, acc, stray, ov, opc, ol, ev, epc, el); end
    end
    vectors++; if (frame_err !== 1'b0 || dp_count !== CW'(m_dp)) begin
      miscompares++; $display("FAIL tlast_status frame_err=%b dp_count=%0d want 0/%0d", frame_err, dp_count, m_dp); end
    @(posedge clk); #1;
    vectors++; if (last !== 1'b0 || valid !== '0) begin
      miscompares++; $display("FAIL tlast_single_pulse last=%b valid=%h want 0/0", last, valid); end
    pulse_finish(2);
  endtask

  task automatic test_frame_err();
    bit acc; int stray; logic [N-1:0] ov, ev; logic [DW-1:0] ox; logic [PW-1:0] opc, epc; logic ol, el;
    int dp_before = m_dp;
    for (int i = 0; i <= 5; i++) begin
      send_beat(DW'($urandom), (i == 5), 0, acc, stray, ov, ox, opc, ol);
      model_accept((i == 5), ev, epc, el);
      vectors++; if (!acc || stray != 0 || ov !== ev || opc !== epc || ol !== el) begin
        miscompares++; $display("FAIL ferr_beat%0d acc=%b valid=%h pc=%0d last=%b want valid=%h pc=%0d last=%b",
                                i, acc, ov, opc, ol, ev, epc, el); end
    end
    vectors++; if (frame_err !== 1'b1 || dp_count !== CW'(dp_before) || tready !== 1'b1) begin
      miscompares++; $display("FAIL ferr_status frame_err=%b dp_count=%0d tready=%b want 1/%0d/1", frame_err, dp_count, tready, dp_before); end
    for (int i = 0; i < N; i++) begin
      send_beat(DW'($urandom), 1'b0, 0, acc, stray, ov, ox, opc, ol);
      model_accept(1'b0, ev, epc, el);
      vectors++; if (!acc || ov !== ev || ol !== el) begin
        miscompares++; $display("FAIL ferr_resync%0d acc=%b valid=%h last=%b want valid=%h last=%b", i, acc, ov, ol, ev, el); end
    end
    vectors++; if (frame_err !== 1'b1 || dp_count !== CW'(m_dp)) begin
      miscompares++; $display("FAIL ferr_sticky frame_err=%b dp_count=%0d want 1/%0d", frame_err, dp_count, m_dp); end
    pulse_finish(1);
  endtask

  task automatic test_reset_mid();
    bit acc; int stray; logic [N-1:0] ov, ev; logic [DW-1:0] ox; logic [PW-1:0] opc, epc; logic ol, el;
    int bad = 0;
    for (int i = 0; i < 8; i++) begin
      send_beat(DW'($urandom), 1'b0, 0, acc, stray, ov, ox, opc, ol);
      model_accept(1'b0, ev, epc, el);
    end
    rst = 1'b1;
    #1;
    vectors++; if (valid !== '0 || x !== '0 || packet_counter !== '0 || last !== 1'b0 || frame_err !== 1'b0
                   || dp_count !== '0 || tready !== 1'b1) begin
      miscompares++; $display("FAIL midrst_outputs valid=%h x=%h pc=%0d last=%b ferr=%b dp=%0d tready=%b want zeros, tready=1",
                              valid, x, packet_counter, last, frame_err, dp_count, tready); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (valid !== '0 || last !== 1'b0 || tready !== 1'b1) bad++;
    end
    vectors++; if (bad != 0) begin
      miscompares++; $display("FAIL midrst_quiet bad_cycles=%0d want 0", bad); end
    for (int i = 0; i < N; i++) begin
      send_beat(DW'(i + 100), 1'b0, 0, acc, stray, ov, ox, opc, ol);
      model_accept(1'b0, ev, epc, el);
      vectors++; if (!acc || ov !== ev || ox !== DW'(i + 100) || opc !== epc || ol !== el) begin
        miscompares++; $display("FAIL midrst_beat%0d acc=%b valid=%h x=%0d pc=%0d want valid=%h x=%0d pc=%0d",
                                i, acc, ov, ox, opc, ev, i + 100, epc); end
    end
    vectors++; if (dp_count !== CW'(m_dp) || tready !== 1'b0) begin
      miscompares++; $display("FAIL midrst_end dp_count=%0d tready=%b want %0d/0", dp_count, tready, m_dp); end
    pulse_finish(0);
  endtask

  task automatic test_gaps();
    bit acc; int stray; logic [N-1:0] ov, ev; logic [DW-1:0] ox, d; logic [PW-1:0] opc, epc; logic ol, el, tl;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < N; i++) begin
        d = (p == 0) ? DW'(i) : {32'($urandom), 32'($urandom)};
        tl = (i == N - 1) && (p != 0) && ($urandom_range(1, 0) == 1);
        send_beat(d, tl, int'($urandom_range(5, 0)), acc, stray, ov, ox, opc, ol);
        model_accept(tl, ev, epc, el);
        vectors++; if (!acc || stray != 0 || ov !== ev || ox !== d || opc !== epc || ol !== el) begin
          miscompares++; $display("FAIL gap_dp%0d_beat%0d acc=%b stray=%0d valid=%h x=%h pc=%0d last=%b want valid=%h x=%h pc=%0d last=%b",
                                  p, i, acc, stray, ov, ox, opc, ol, ev, d, epc, el); end
      end
      vectors++; if (dp_count !== CW'(m_dp) || tready !== 1'b0 || frame_err !== 1'(m_err)) begin
        miscompares++; $display("FAIL gap_dp%0d_end dp_count=%0d tready=%b ferr=%b want %0d/0/%0b", p, dp_count, tready, frame_err, m_dp, m_err); end
      pulse_finish(int'($urandom_range(5, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait_finish();
    test_frame_err();
    test_reset_mid();
    test_gaps();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
